pc_redirect_unit: RTL

- Program counter register and next-PC selection for the MIPS fetch stage.
- Consumes the word-aligned branch offset produced by the shift-left-by-2 stage, the jump index, and the JR register target.
- Produces the fetch PC and PC+4.
- Implements the architectural branch delay slot with a two-state FSM: the instruction after a taken branch or jump always executes before the redirect.

---
 rtl/pc_redirect_unit_if.sv | 40 ++++
 rtl/pc_redirect_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - redirect request / fetch PC bundle between decode and fetch
//
// Purpose: groups the redirect requests coming from decode/execute and the
// fetch-side PC outputs of pc_redirect_unit.
// Signals:
//   stall             : hold PC, state and latched target
//   branch_taken      : conditional branch resolved taken
//   branch_offset_sl2 : sign-extended immediate already shifted left by 2
//   jump, jump_index  : J/JAL request and its instr_index field
//   jr, jr_target     : JR/JALR request and its register-sourced target
//   pc, pc_plus4      : current fetch address and pc + 4
//   in_delay_slot     : current pc is a delay-slot instruction
//   target_misaligned : one-cycle pulse, accepted JR target had low bits set
//   redirect_dropped  : one-cycle pulse, request ignored in the delay slot
// Modports: slave = the PC unit, master = the requesting side.

interface pc_redirect_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset_sl2;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_delay_slot;
    logic        target_misaligned;
    logic        redirect_dropped;

    modport slave (
        input  stall, branch_taken, branch_offset_sl2, jump, jump_index, jr, jr_target,
        output pc, pc_plus4, in_delay_slot, target_misaligned, redirect_dropped
    );

    modport master (
        output stall, branch_taken, branch_offset_sl2, jump, jump_index, jr, jr_target,
        input  pc, pc_plus4, in_delay_slot, target_misaligned, redirect_dropped
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - MIPS fetch program counter with delay-slot redirect FSM
//
// Purpose: holds the fetch PC, computes PC+4 and selects the next PC from
// JR (highest priority), J/JAL, or a taken branch. With DELAY_SLOT = 1 the
// instruction after a redirect request is always fetched before the redirect
// lands; with DELAY_SLOT = 0 the redirect lands on the next advance.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pc_redirect_unit_if.slave (requests in, pc / status out)

module pc_redirect_unit #(
    parameter int              DATA_W     = 32,
    parameter logic [31:0]     RESET_PC   = 32'h0000_0000,
    parameter bit              DELAY_SLOT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_redirect_unit_if.slave    bus
);

    typedef enum logic {SEQ = 1'b0, SLOT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   target_q, target_d;
    logic                target_misaligned_q, target_misaligned_d;
    logic                redirect_dropped_q, redirect_dropped_d;

    logic [DATA_W-1:0]   pc_plus4;
    logic [DATA_W-1:0]   sel_target;
    logic                any_req;
    logic                jr_misaligned;

    // Target selection: jr > jump > branch; lower requests are simply masked.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        any_req       = bus.jr | bus.jump | bus.branch_taken;
        jr_misaligned = bus.jr && (bus.jr_target[1:0] != 2'b00);
        if (bus.jr) begin
            sel_target = {bus.jr_target[DATA_W-1:2], 2'b00};
        end else if (bus.jump) begin
            sel_target = {pc_plus4[DATA_W-1:DATA_W-4], bus.jump_index, 2'b00};
        end else begin
            sel_target = pc_plus4 + bus.branch_offset_sl2;
        end
    end

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        target_d            = target_q;
        target_misaligned_d = 1'b0;
        redirect_dropped_d  = 1'b0;

        if (!bus.stall) begin
            if (DELAY_SLOT) begin
                unique case (state_q)
                    SEQ: begin
                        // The delay-slot instruction is fetched next; the
                        // target waits in target_q for one more advance.
                        pc_d = pc_plus4;
                        if (any_req) begin
                            target_d            = sel_target;
                            state_d             = SLOT;
                            target_misaligned_d = jr_misaligned;
                        end
                    end
                    SLOT: begin
                        // A redirect inside the delay slot is architecturally
                        // undefined; it is dropped and reported.
                        pc_d               = target_q;
                        state_d            = SEQ;
                        redirect_dropped_d = any_req;
                    end
                    default: state_d = SEQ;
                endcase
            end else begin
                pc_d                = any_req ? sel_target : pc_plus4;
                target_misaligned_d = jr_misaligned;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= SEQ;
            pc_q                <= RESET_PC;
            target_q            <= '0;
            target_misaligned_q <= 1'b0;
            redirect_dropped_q  <= 1'b0;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            target_q            <= target_d;
            target_misaligned_q <= target_misaligned_d;
            redirect_dropped_q  <= redirect_dropped_d;
        end
    end

    assign bus.pc                = pc_q;
    assign bus.pc_plus4          = pc_plus4;
    assign bus.in_delay_slot     = (state_q == SLOT);
    assign bus.target_misaligned = target_misaligned_q;
    assign bus.redirect_dropped  = redirect_dropped_q;

endmodule
